// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed single-MAC FIR engine with ring-buffer delay line
// Optional: define FIR_MAC_SATURATE_EN to clamp the shifted accumulator instead of wrapping it.
module fir_mac_sequencer #(
  parameter int TAPS   = 74,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 23,
  parameter int SHIFT  = 8,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic [AW-1:0]            coef_addr,
  output logic                     coef_rd_en,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, RUN, LAST, OUT} state_t;

  localparam int PW = DATA_W + COEF_W;
  localparam int SW = ACC_W - SHIFT;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic [AW-1:0] K_WRAP = AW'(TAPS);

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] ring [TAPS];
  logic [AW-1:0]            wp, cur, k, rd_idx;
  logic signed [DATA_W-1:0] sample_reg;
  logic                     mac_vld;
  logic signed [ACC_W-1:0]  acc, acc_sum, prod_ext;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     acc_shift;
  logic signed [DATA_W-1:0] result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    coef_rd_en = 1'b0;
    coef_addr  = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        coef_rd_en = 1'b1;
        coef_addr  = k;
        if (k == K_LAST) state_nxt = LAST;
      end
      LAST:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tap k pairs coefficient k with the sample k positions older than the newest one.
  assign rd_idx = (cur >= k) ? (cur - k) : (cur + K_WRAP - k);

  // ROM data and sample_reg both arrive one cycle after the read strobe.
  assign prod     = coef_data * sample_reg;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_sum  = mac_vld ? (acc + prod_ext) : acc;
  assign acc_shift = acc_sum[ACC_W-1:SHIFT];

`ifdef FIR_MAC_SATURATE_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_W-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (DATA_W-1)));

  always_comb begin
    result = acc_shift[DATA_W-1:0];
    if (acc_shift > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (acc_shift < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
  end
`else
  assign result = acc_shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) ring[i] <= '0;
      wp         <= '0;
      cur        <= '0;
      k          <= '0;
      sample_reg <= '0;
      mac_vld    <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      mac_vld <= coef_rd_en;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ring[wp] <= in_sample;
            cur      <= wp;
            wp       <= (wp == K_LAST) ? '0 : wp + 1'b1;
            acc      <= '0;
            k        <= '0;
          end
        end
        RUN: begin
          sample_reg <= ring[rd_idx];
          acc        <= acc_sum;
          if (k != K_LAST) k <= k + 1'b1;
        end
        LAST: begin
          acc        <= acc_sum;
          out_sample <= result;
          out_valid  <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
